// File: rtl/dmem_mmio_unit_pkg.sv
// Shared definitions for the data-memory / MMIO unit: access-type codes, MMIO offsets, size helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package dmem_mmio_unit_pkg;

    // Access-type codes as driven by the core's DMType_out.
    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    // MMIO register byte offsets from the region base.
    localparam logic [15:0] MMIO_LED   = 16'h0000;
    localparam logic [15:0] MMIO_SW    = 16'h0004;
    localparam logic [15:0] MMIO_CYCLE = 16'h0008;
    localparam logic [15:0] MMIO_ERR   = 16'h000C;

    typedef enum logic [1:0] {
        SZ_WORD,
        SZ_HALF,
        SZ_BYTE
    } acc_size_e;

    // Unknown codes fall back to word accesses.
    function automatic acc_size_e decode_size(input logic [2:0] dm_type);
        acc_size_e sz;
        case (dm_type)
            DM_HALF, DM_HALF_U: sz = SZ_HALF;
            DM_BYTE, DM_BYTE_U: sz = SZ_BYTE;
            default:            sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic is_signed_load(input logic [2:0] dm_type);
        return (dm_type == DM_HALF) || (dm_type == DM_BYTE);
    endfunction

    function automatic logic size_misaligned(input acc_size_e sz, input logic [1:0] offs);
        logic mis;
        case (sz)
            SZ_WORD: mis = (offs != 2'b00);
            SZ_HALF: mis = offs[0];
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane alignment for RAM accesses: store byte-enables/replication, load extraction/extension.
// Latency: purely combinational.
// Backpressure: none.
// Ports: dm_type/offs select size and lane; st_dat -> st_be/st_rep for stores;
//        ld_word (addressed RAM word) -> ld_dat (extended, right-aligned).
module dm_lane_align
    import dmem_mmio_unit_pkg::*;
(
    input  logic [2:0]  dm_type,
    input  logic [1:0]  offs,
    input  logic [31:0] st_dat,
    output logic [3:0]  st_be,
    output logic [31:0] st_rep,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_dat
);

    acc_size_e   sz;
    logic        sgn;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        sz      = decode_size(dm_type);
        sgn     = is_signed_load(dm_type);
        st_be   = 4'b1111;
        st_rep  = st_dat;
        ld_dat  = ld_word;
        ld_byte = ld_word[{offs, 3'b000} +: 8];
        ld_half = offs[1] ? ld_word[31:16] : ld_word[15:0];
        case (sz)
            SZ_BYTE: begin
                // Replicate so whichever lane is enabled sees the byte.
                st_be  = 4'b0001 << offs;
                st_rep = {4{st_dat[7:0]}};
                ld_dat = {{24{sgn & ld_byte[7]}}, ld_byte};
            end
            SZ_HALF: begin
                st_be  = offs[1] ? 4'b1100 : 4'b0011;
                st_rep = {2{st_dat[15:0]}};
                ld_dat = {{16{sgn & ld_half[15]}}, ld_half};
            end
            default: begin
                st_be  = 4'b1111;
                st_rep = st_dat;
                ld_dat = ld_word;
            end
        endcase
    end

endmodule

// File: rtl/dmem_mmio_unit.sv
// Data RAM plus MMIO registers (LED, synchronised switches, cycle counter, sticky misalign error).
// Latency: loads are combinational (0 cycles); stores commit at the rising edge with mem_w high.
// Backpressure: none; one access is accepted every cycle.
// Ports: clk/rst (sync, active-high); mem_w/rd_en qualify the access; addr/wdata/dm_type from
//        the core MEM stage; rdata back to the core; sw_i board switches; led_o LED register;
//        err_o/err_addr_o sticky misaligned-access flag and first offending address.
// Build option: define DMEM_MMIO_EN to include the MMIO region; without it every address is RAM,
//        led_o is 0 and the error flag can only be cleared by reset.
module dmem_mmio_unit
    import dmem_mmio_unit_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_w,
    input  logic        rd_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  dm_type,
    output logic [31:0] rdata,
    input  logic [15:0] sw_i,
    output logic [15:0] led_o,
    output logic        err_o,
    output logic [31:0] err_addr_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   ram [DEPTH_WORDS];
    logic [AW-1:0] ram_idx;
    logic [31:0]   ram_word;
    logic [31:0]   ram_merged;
    logic [31:0]   be_mask;

    logic [3:0]    st_be;
    logic [31:0]   st_rep;
    logic [31:0]   ld_dat;

    acc_size_e     acc_sz;
    logic          mmio_sel;
    logic          acc_mis;
    logic          err_hit;
    logic          st_ok;
    logic          ram_we;
    logic          mmio_we;
    logic          err_clr;
    logic [31:0]   mmio_rdata;

    logic          err_q;
    logic [31:0]   err_addr_q;

    // Upper address bits above the RAM index are intentionally ignored (aliasing).
    logic          unused_addr_hi;
    assign unused_addr_hi = ^addr[31:AW+2];

    // ------------------------------------------------------------------
    // Decode and misalignment
    // ------------------------------------------------------------------
`ifdef DMEM_MMIO_EN
    assign mmio_sel = (addr[31:16] == MMIO_BASE[31:16]);
`else
    assign mmio_sel = 1'b0;
`endif

    assign acc_sz  = decode_size(dm_type);
    // MMIO registers only take word accesses; anything narrower is treated as misaligned.
    assign acc_mis = size_misaligned(acc_sz, addr[1:0]) | (mmio_sel & (acc_sz != SZ_WORD));
    // The core drives word/ALU-result addresses on non-memory cycles, so only qualified
    // accesses may raise the error.
    assign err_hit = (mem_w | rd_en) & acc_mis;
    assign st_ok   = mem_w & ~acc_mis & ~rst;
    assign ram_we  = st_ok & ~mmio_sel;
    assign mmio_we = st_ok & mmio_sel;

    // ------------------------------------------------------------------
    // RAM (contents deliberately not reset)
    // ------------------------------------------------------------------
    assign ram_idx  = addr[AW+1:2];
    assign ram_word = ram[ram_idx];

    dm_lane_align u_lane (
        .dm_type (dm_type),
        .offs    (addr[1:0]),
        .st_dat  (wdata),
        .st_be   (st_be),
        .st_rep  (st_rep),
        .ld_word (ram_word),
        .ld_dat  (ld_dat)
    );

    assign be_mask    = {{8{st_be[3]}}, {8{st_be[2]}}, {8{st_be[1]}}, {8{st_be[0]}}};
    assign ram_merged = (ram_word & ~be_mask) | (st_rep & be_mask);

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= ram_merged;
        end
    end

    // ------------------------------------------------------------------
    // MMIO registers
    // ------------------------------------------------------------------
`ifdef DMEM_MMIO_EN
    logic [15:0] led_q;
    logic [15:0] sw_s1;
    logic [15:0] sw_s2;
    logic [31:0] cycle_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q   <= 16'h0000;
            sw_s1   <= 16'h0000;
            sw_s2   <= 16'h0000;
            cycle_q <= 32'h0000_0000;
        end else begin
            sw_s1   <= sw_i;
            sw_s2   <= sw_s1;
            cycle_q <= cycle_q + 32'd1;
            if (mmio_we && (addr[15:0] == MMIO_LED)) begin
                led_q <= wdata[15:0];
            end
        end
    end

    assign err_clr = mmio_we && (addr[15:0] == MMIO_ERR);
    assign led_o   = led_q;

    always_comb begin
        mmio_rdata = 32'h0000_0000;
        case (addr[15:0])
            MMIO_LED:   mmio_rdata = {16'h0000, led_q};
            MMIO_SW:    mmio_rdata = {16'h0000, sw_s2};
            MMIO_CYCLE: mmio_rdata = cycle_q;
            MMIO_ERR:   mmio_rdata = {31'b0, err_q};
            default:    mmio_rdata = 32'h0000_0000;
        endcase
    end
`else
    logic unused_sw;
    assign unused_sw  = ^sw_i;
    assign err_clr    = 1'b0;
    assign led_o      = 16'h0000;
    assign mmio_rdata = 32'h0000_0000;
`endif

    // ------------------------------------------------------------------
    // Load return
    // ------------------------------------------------------------------
    always_comb begin
        rdata = ld_dat;
        if (acc_mis) begin
            rdata = 32'h0000_0000;
        end else if (mmio_sel) begin
            rdata = mmio_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Sticky misaligned-access capture; a new error beats a same-edge clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q      <= 1'b0;
            err_addr_q <= 32'h0000_0000;
        end else if (err_hit && (!err_q || err_clr)) begin
            err_q      <= 1'b1;
            err_addr_q <= addr;
        end else if (err_clr) begin
            err_q      <= 1'b0;
            err_addr_q <= 32'h0000_0000;
        end
    end

    assign err_o      = err_q;
    assign err_addr_o = err_addr_q;

endmodule

// File: doc/dmem_mmio_unit.md
# dmem_mmio_unit

Data-memory and memory-mapped I/O unit downstream of the pipeline core's MEM stage. It consumes the core's `mem_w`, `Addr_out`, `Data_out` and `DMType_out` outputs and returns load data on the core's `Data_in` input in the same cycle. It provides word-organised RAM with byte and halfword lane handling, a small MMIO register file (LEDs, synchronised switches, cycle counter) and sticky misaligned-access capture.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1024: RAM depth in 32-bit words; must be a power of two.
- `MMIO_BASE`, default 32'hFFFF_0000: MMIO region base; only bits [31:16] are decoded.

Ports:
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `mem_w`  in  1: store enable (core MEM stage).
- `addr`  in  32: byte address (core `Addr_out`).
- `wdata`  in  32: store data, right-aligned (core `Data_out`).
- `dm_type`  in  3: access type (core `DMType_out`).
- `rdata`  out  32: load data, extended and right-aligned (core `Data_in`).
- `sw_i`  in  16: asynchronous board switches.
- `led_o`  out  16: LED register.
- `err_o`  out  1: sticky misaligned-access flag.
- `err_addr_o`  out  32: address of the first misaligned access since the flag was last cleared.

## Operation
- dm_type codes: 000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned. Any other code is treated as word.
- Region select: MMIO when `addr[31:16]==MMIO_BASE[31:16]`, otherwise RAM. RAM index is `addr[log2(DEPTH_WORDS)+1:2]`; higher bits are ignored, so addresses alias modulo depth.
- Misaligned access: word access with `addr[1:0]!=0`, or half access with `addr[0]==1`.
  - Store: suppressed.
  - Read: `rdata` is 0.
  - If `err_o==0`: set `err_o` and capture `addr` into `err_addr_o`. If already set, the captured address is held.
  - Detection applies to every cycle regardless of `mem_w`. The core drives `dm_type=000` and `addr` equal to the ALU result for non-memory instructions, so the core gates loads through the `MemRead` path.
  - Because of this, error detection is enabled only when `mem_w==1` or `rd_en==1`, where `rd_en` is an additional input: `rd_en  in  1  load qualifier (core MemRead_MEM)`.
- RAM store:
  - Byte enables come from `addr[1:0]` and the size.
  - Store data is replicated into the selected lanes: byte goes to lane `addr[1:0]`, half goes to lanes {`addr[1]`*2 +1, +0}.
- RAM load: the addressed word is read combinationally. The byte or half at the lane offset is selected, then sign-extended (000/001/011) or zero-extended (010/100).
- MMIO registers, at word offsets from the base (MMIO accesses must be word-sized; other sizes count as misaligned):
  - 0x00 LED: RW; bits [15:0] written from `wdata[15:0]`; reads zero-extended.
  - 0x04 SW: RO; 2-flop synchronised `sw_i`, zero-extended.
  - 0x08 CYCLE: RO; 32-bit free-running counter, increments every cycle, wraps from 0xFFFF_FFFF to 0.
  - 0x0C ERR: reads `{31'b0, err_o}`; any store clears `err_o` and `err_addr_o`.
  - Other offsets: read 0; writes ignored.
- Reset values:
  - `led_o=0`, CYCLE=0, sync flops 0, `err_o=0`, `err_addr_o=0`.
  - RAM contents are not cleared.
  - A store presented during a reset cycle is ignored.

## Timing
- Load latency is 0: `rdata` is combinational from `addr`, `dm_type` and state in the same cycle.
- Store commits at the rising edge where `mem_w==1`. A same-cycle read of that address returns the old data; the next cycle returns the new data.
- Switch latency: a change on `sw_i` is visible at 0x04 after 2 edges.
- Same-edge ERR-clear store and a new misaligned access: the new error wins; the flag is set and the new address captured.
- CYCLE read in cycle N returns the count after N edges since reset release.

## Configuration
- `DMEM_MMIO_EN` defined: MMIO decode, registers and the switch synchroniser are present.
- `DMEM_MMIO_EN` undefined:
  - All addresses map to RAM.
  - `led_o` is tied to 0.
  - `err_o` and `err_addr_o` still function, but no clear path exists; they clear only by reset.

## Structure
- The dm_type codes stay in the shared `ctrl_encode_def.v` header. Add MMIO offset constants `MMIO_LED`, `MMIO_SW`, `MMIO_CYCLE`, `MMIO_ERR` there.
- One sub-module, `dm_lane_align`: combinational store byte-enable/replication and load extraction/extension, parameterless, reused by RAM path only.

## Test plan
- Store word 0x8765_4321 at 0x10, then load byte at 0x13 with dm_type 011 -> 0xFFFF_FF87; load 100 -> 0x0000_0087; load half 001 at 0x12 -> 0xFFFF_8765.
- Store byte 0xAB at 0x21 over word 0 -> word load at 0x20 returns 0x0000_AB00. Same-cycle read during the store -> 0x0000_0000.
- Word store at 0x22 with `mem_w=1` -> RAM unchanged, `err_o=1`, `err_addr_o=0x22`. A second misaligned access at 0x31 leaves `err_addr_o=0x22`. Store to 0xFFFF_000C -> `err_o=0`.
- Store 0x1234_5A5A to 0xFFFF_0000 -> `led_o=0x5A5A`. Assert `rst` -> `led_o=0`, CYCLE read next cycle = 1.
- Toggle `sw_i` to 0x00F0 -> 0xFFFF_0004 reads 0 after 1 edge and 0x0000_00F0 after 2 edges.
- With `DEPTH_WORDS=1024`, store at 0x1000 then load 0x0 -> same word (aliasing). Build without `DEPTH_WORDS`/`DMEM_MMIO_EN` -> load at 0xFFFF_0000 hits RAM.
